// File: rtl/eca_pkg.sv
// Shared types, widths and helpers for the erasure-coding job sequencer.
// All derived widths come from the base parameters below.
package eca_pkg;

    localparam int K_MAX            = 4;
    localparam int K_MIN            = 2;
    localparam int M_MAX            = 4;
    localparam int M_MIN            = 2;
    localparam int W                = 4;
    localparam int PACKET_LENGTH    = 2;
    localparam int BM_MULT_UNIT_NUM = 4;
    localparam int MAX_STRIPES      = 256;
    localparam int TIMEOUT_CYC      = 1024;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SEL_W      = $clog2(K_MAX);
    localparam int XU         = BM_MULT_UNIT_NUM / K_MIN;
    localparam int BM_MEM_W   = W * W * K_MAX;
    localparam int BM_ADDR_W  = $clog2(M_MAX);
    localparam int DATA_W     = W * PACKET_LENGTH * K_MAX;
    localparam int HIN_W      = max_of(BM_MEM_W, DATA_W);
    localparam int SC_W       = $clog2(MAX_STRIPES + 1);
    localparam int KW         = $clog2(K_MAX + 1);
    localparam int MW         = $clog2(M_MAX + 1);
    localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int SEL_BUS_W  = BM_MULT_UNIT_NUM * SEL_W;
    localparam int MASK_BUS_W = XU * K_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BM,
        S_LOAD_REG,
        S_LOAD_DATA,
        S_RUN,
        S_DONE
    } eca_seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CMD     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    // Unit i multiplies data packet (i mod k).
    function automatic logic [SEL_BUS_W-1:0] mux_sel_of(input logic [KW-1:0] k);
        logic [SEL_BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < BM_MULT_UNIT_NUM; i++)
            r[i*SEL_W +: SEL_W] = SEL_W'(i % int'(k));
        return r;
    endfunction

    function automatic logic [MASK_BUS_W-1:0] mask_of(input logic [KW-1:0] k);
        logic [K_MAX-1:0] one;
        one = K_MAX'((32'd1 << k) - 32'd1);
        return {XU{one}};
    endfunction

endpackage

// File: rtl/eca_cfg_seq_if.sv
// Host-side stream bundle: inbound loads and outbound parity words.
interface eca_cfg_seq_if;
    import eca_pkg::*;

    logic              host_in_valid;
    logic              host_in_ready;
    logic [HIN_W-1:0]  host_in_data;
    logic              host_out_valid;
    logic              host_out_ready;
    logic [DATA_W-1:0] host_out_data;

    modport master (
        output host_in_valid, host_in_data, host_out_ready,
        input  host_in_ready, host_out_valid, host_out_data
    );

    modport slave (
        input  host_in_valid, host_in_data, host_out_ready,
        output host_in_ready, host_out_valid, host_out_data
    );

endinterface

// File: rtl/eca_seq_out_reg.sv
// One-entry valid/ready holding register; flush drops the held word.
module eca_seq_out_reg
    import eca_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && !(out_valid && !out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/eca_cfg_seq.sv
// Job sequencer for eca_top: loads bitmatrix, mux/mask registers and
// data stripes, then runs the engine and returns parity words.
module eca_cfg_seq
    import eca_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [KW-1:0]         cmd_k,
    input  logic [MW-1:0]         cmd_m,
    input  logic [SC_W-1:0]       cmd_stripes,
    input  logic                  cmd_abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    eca_cfg_seq_if.slave          h,
    output logic                  user_bm_mem_wr_req,
    output logic [BM_ADDR_W-1:0]  user_bm_mem_wr_addr,
    output logic [BM_MEM_W-1:0]   user_bm_mem_wr_data,
    output logic                  bmu_bm_mux_sel_reg_wr,
    output logic [SEL_BUS_W-1:0]  bmu_bm_mux_sel_reg_din,
    output logic                  and_mask_mask_reg_wr,
    output logic [MASK_BUS_W-1:0] and_mask_mask_reg_din,
    output logic [MW-1:0]         m_val,
    output logic                  inbuf_wr_req,
    output logic [DATA_W-1:0]     inbuf_wr_data,
    input  logic                  inbuf_full,
    output logic                  outbuf_rd_req,
    input  logic                  outbuf_empty,
    input  logic                  outbuf_rd_data_val,
    input  logic [DATA_W-1:0]     outbuf_rd_data,
    output logic                  eca_en,
    output logic                  engine_en
);

    eca_seq_state_t    state;
    logic [KW-1:0]     k_q;
    logic [MW-1:0]     m_q;
    logic [SC_W-1:0]   s_q;
    logic [SC_W-1:0]   cnt;
    logic [SC_W-1:0]   rd_cnt;
    logic [TMO_W-1:0]  tmo;
    logic              rdy;
    logic              pend;
    logic              acc;
    logic              cmd_ok;
    logic              tmo_hit;
    logic              kill;
    logic              can_rd;
    logic              cap;
    logic              out_hs;
    logic              ov;
    logic [DATA_W-1:0] od;

    // Ready is registered; only the inbuf back-pressure is folded in late
    // so no word is ever written while the input buffer is full.
    assign h.host_in_ready = rdy && (state != S_LOAD_DATA || !inbuf_full);
    assign acc = h.host_in_valid && h.host_in_ready;

    assign user_bm_mem_wr_req  = acc && state == S_LOAD_BM;
    assign user_bm_mem_wr_addr = cnt[BM_ADDR_W-1:0];
    assign user_bm_mem_wr_data = h.host_in_data[BM_MEM_W-1:0];
    assign inbuf_wr_req        = acc && state == S_LOAD_DATA;
    assign inbuf_wr_data       = h.host_in_data[DATA_W-1:0];
    assign engine_en           = eca_en;

    assign cmd_ok = cmd_k >= KW'(K_MIN) && cmd_k <= KW'(K_MAX)
                 && cmd_m >= MW'(M_MIN) && cmd_m <= MW'(M_MAX)
                 && cmd_stripes != '0
                 && cmd_stripes <= SC_W'(MAX_STRIPES);

    assign tmo_hit = state == S_RUN && !outbuf_rd_data_val
                  && tmo == TMO_W'(TIMEOUT_CYC - 1);
    assign kill    = state != S_IDLE && (cmd_abort || tmo_hit);
    assign out_hs  = ov && h.host_out_ready;
    assign can_rd  = state == S_RUN && !outbuf_empty && !ov && !pend
                  && rd_cnt < s_q;
    assign cap     = state == S_RUN && pend && outbuf_rd_data_val;

    eca_seq_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (kill),
        .in_valid  (cap),
        .in_data   (outbuf_rd_data),
        .out_valid (ov),
        .out_ready (h.host_out_ready),
        .out_data  (od)
    );

    assign h.host_out_valid = ov;
    assign h.host_out_data  = od;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= S_IDLE;
            k_q                    <= '0;
            m_q                    <= '0;
            s_q                    <= '0;
            cnt                    <= '0;
            rd_cnt                 <= '0;
            tmo                    <= '0;
            rdy                    <= 1'b0;
            pend                   <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            err_code               <= ERR_NONE;
            bmu_bm_mux_sel_reg_wr  <= 1'b0;
            bmu_bm_mux_sel_reg_din <= '0;
            and_mask_mask_reg_wr   <= 1'b0;
            and_mask_mask_reg_din  <= '0;
            m_val                  <= '0;
            outbuf_rd_req          <= 1'b0;
            eca_en                 <= 1'b0;
        end else begin
            bmu_bm_mux_sel_reg_wr <= 1'b0;
            and_mask_mask_reg_wr  <= 1'b0;
            done                  <= 1'b0;
            outbuf_rd_req         <= 1'b0;
            if (kill) begin
                state    <= S_IDLE;
                err      <= 1'b1;
                err_code <= cmd_abort ? ERR_ABORT : ERR_TIMEOUT;
                rdy      <= 1'b0;
                pend     <= 1'b0;
                busy     <= 1'b0;
                eca_en   <= 1'b0;
                m_val    <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (cmd_start && !cmd_abort) begin
                            if (cmd_ok) begin
                                k_q      <= cmd_k;
                                m_q      <= cmd_m;
                                s_q      <= cmd_stripes;
                                cnt      <= '0;
                                err      <= 1'b0;
                                err_code <= ERR_NONE;
                                rdy      <= 1'b1;
                                busy     <= 1'b1;
                                state    <= S_LOAD_BM;
                            end else begin
                                err      <= 1'b1;
                                err_code <= ERR_CMD;
                            end
                        end
                    end
                    S_LOAD_BM: begin
                        if (acc) begin
                            if (cnt + SC_W'(1) == SC_W'(m_q)) begin
                                cnt                    <= '0;
                                rdy                    <= 1'b0;
                                bmu_bm_mux_sel_reg_wr  <= 1'b1;
                                bmu_bm_mux_sel_reg_din <= mux_sel_of(k_q);
                                and_mask_mask_reg_wr   <= 1'b1;
                                and_mask_mask_reg_din  <= mask_of(k_q);
                                m_val                  <= m_q;
                                state                  <= S_LOAD_REG;
                            end else begin
                                cnt <= cnt + SC_W'(1);
                            end
                        end
                    end
                    S_LOAD_REG: begin
                        rdy   <= 1'b1;
                        state <= S_LOAD_DATA;
                    end
                    S_LOAD_DATA: begin
                        if (acc) begin
                            if (cnt + SC_W'(1) == s_q) begin
                                cnt    <= '0;
                                rd_cnt <= '0;
                                tmo    <= '0;
                                rdy    <= 1'b0;
                                pend   <= 1'b0;
                                eca_en <= 1'b1;
                                state  <= S_RUN;
                            end else begin
                                cnt <= cnt + SC_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        if (outbuf_rd_data_val) begin
                            pend <= 1'b0;
                            tmo  <= '0;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                        if (can_rd) begin
                            outbuf_rd_req <= 1'b1;
                            pend          <= 1'b1;
                            rd_cnt        <= rd_cnt + SC_W'(1);
                        end
                        if (out_hs) begin
                            if (cnt + SC_W'(1) == s_q) begin
                                cnt    <= '0;
                                eca_en <= 1'b0;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                cnt <= cnt + SC_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        m_val <= '0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
